block_dispatcher: RTL and testbench

- Parametrised thread-block dispatcher between the kernel control registers and the compute cores.
- Hands block IDs 0..num_blocks-1 to any number of cores, one grant per cycle, using round-robin arbitration over a core-enable mask.
- Gives each core a per-block reset pulse, then a start level, and retires blocks on core_done.
- Counts retired blocks and raises done when the kernel completes. Flags an error when a kernel is launched with no usable cores.

---
 rtl/block_dispatcher.sv | 194 +++++++++++++++++++
 tb/tb_block_dispatcher.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/block_dispatcher.sv
// Thread-block dispatcher: hands block IDs to cores round-robin and retires them on core_done.
// Optional kernel cycle counter is built only when BLOCK_DISPATCHER_STATS_EN is defined.
module block_dispatcher #(
  parameter int NUM_CORES      = 2,
  parameter int BLOCK_ID_WIDTH = 8
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                start,
  input  logic [BLOCK_ID_WIDTH:0]             num_blocks,
  input  logic [NUM_CORES-1:0]                core_enable,
  input  logic [NUM_CORES-1:0]                core_done,
  output logic [NUM_CORES-1:0]                core_start,
  output logic [NUM_CORES-1:0]                core_reset,
  output logic [NUM_CORES*BLOCK_ID_WIDTH-1:0] core_block_id,
  output logic [BLOCK_ID_WIDTH:0]             blocks_done,
  output logic                                done,
  output logic                                error,
  output logic [31:0]                         kernel_cycles
);

  localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int CNT_W = BLOCK_ID_WIDTH + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_DISPATCH, ST_DONE} state_t;
  typedef enum logic [1:0] {SLOT_FREE, SLOT_RST, SLOT_RUN} slot_t;

  state_t               state_reg;
  logic [CNT_W-1:0]     num_blocks_reg;
  logic [CNT_W-1:0]     next_id_reg;
  logic [CNT_W-1:0]     blocks_done_reg;
  logic [NUM_CORES-1:0] enable_reg;
  logic [PTR_W-1:0]     rr_ptr_reg;
  logic                 done_reg;
  logic                 error_reg;

  logic [NUM_CORES-1:0] slot_free;
  logic [NUM_CORES-1:0] retire;
  logic [NUM_CORES-1:0] eligible;
  logic                 grant_valid;
  logic [PTR_W-1:0]     grant_idx;
  logic [CNT_W-1:0]     retire_count;
  logic                 start_accept;

  assign start_accept = start && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));

  // Round-robin pick: lowest eligible index at or above rr_ptr, else lowest overall (wrap).
  always_comb begin
    logic             hi_hit;
    logic [PTR_W-1:0] hi_idx;
    logic             lo_hit;
    logic [PTR_W-1:0] lo_idx;
    hi_hit   = 1'b0;
    hi_idx   = '0;
    lo_hit   = 1'b0;
    lo_idx   = '0;
    eligible = '0;
    if ((state_reg == ST_DISPATCH) && (next_id_reg < num_blocks_reg)) begin
      eligible = slot_free & enable_reg;
    end
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        if (PTR_W'(i) >= rr_ptr_reg) begin
          hi_hit = 1'b1;
          hi_idx = PTR_W'(i);
        end
        lo_hit = 1'b1;
        lo_idx = PTR_W'(i);
      end
    end
    grant_valid = lo_hit;
    grant_idx   = hi_hit ? hi_idx : lo_idx;
  end

  always_comb begin
    retire_count = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      retire_count = retire_count + CNT_W'(retire[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= ST_IDLE;
      num_blocks_reg  <= '0;
      enable_reg      <= '0;
      next_id_reg     <= '0;
      blocks_done_reg <= '0;
      rr_ptr_reg      <= '0;
      done_reg        <= 1'b0;
      error_reg       <= 1'b0;
    end else begin
      if (grant_valid) begin
        next_id_reg <= next_id_reg + 1'b1;
        rr_ptr_reg  <= (grant_idx == PTR_W'(NUM_CORES - 1)) ? '0 : grant_idx + 1'b1;
      end
      blocks_done_reg <= blocks_done_reg + retire_count;

      if (start_accept) begin
        num_blocks_reg  <= num_blocks;
        enable_reg      <= core_enable;
        next_id_reg     <= '0;
        blocks_done_reg <= '0;
        done_reg        <= 1'b0;
        error_reg       <= 1'b0;
        if (num_blocks == '0) begin
          state_reg <= ST_DONE;
          done_reg  <= 1'b1;
        end else if (core_enable == '0) begin
          state_reg <= ST_DONE;
          done_reg  <= 1'b1;
          error_reg <= 1'b1;
        end else begin
          state_reg <= ST_DISPATCH;
        end
      end else if ((state_reg == ST_DISPATCH) && (blocks_done_reg == num_blocks_reg)) begin
        state_reg <= ST_DONE;
        done_reg  <= 1'b1;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_core
    slot_t                     slot_reg;
    logic                      start_reg;
    logic                      rst_reg;
    logic [BLOCK_ID_WIDTH-1:0] block_id_reg;

    // Block ID is left in place after retirement until this core is granted again.
    always_ff @(posedge clk) begin
      if (reset) begin
        slot_reg     <= SLOT_FREE;
        start_reg    <= 1'b0;
        rst_reg      <= 1'b0;
        block_id_reg <= '0;
      end else begin
        case (slot_reg)
          SLOT_FREE: begin
            if (grant_valid && (grant_idx == PTR_W'(gi))) begin
              block_id_reg <= next_id_reg[BLOCK_ID_WIDTH-1:0];
              rst_reg      <= 1'b1;
              slot_reg     <= SLOT_RST;
            end
          end
          SLOT_RST: begin
            rst_reg   <= 1'b0;
            start_reg <= 1'b1;
            slot_reg  <= SLOT_RUN;
          end
          SLOT_RUN: begin
            if (core_done[gi]) begin
              start_reg <= 1'b0;
              slot_reg  <= SLOT_FREE;
            end
          end
          default: begin
            start_reg <= 1'b0;
            rst_reg   <= 1'b0;
            slot_reg  <= SLOT_FREE;
          end
        endcase
      end
    end

    assign slot_free[gi] = (slot_reg == SLOT_FREE);
    assign retire[gi]    = (slot_reg == SLOT_RUN) && core_done[gi];
    assign core_start[gi] = start_reg;
    assign core_reset[gi] = rst_reg;
    assign core_block_id[gi*BLOCK_ID_WIDTH +: BLOCK_ID_WIDTH] = block_id_reg;
  end

  assign blocks_done = blocks_done_reg;
  assign done        = done_reg;
  assign error       = error_reg;

`ifdef BLOCK_DISPATCHER_STATS_EN
  logic [31:0] cycles_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      cycles_reg <= '0;
    end else if (start_accept) begin
      cycles_reg <= '0;
    end else if ((state_reg == ST_DISPATCH) && (cycles_reg != 32'hFFFF_FFFF)) begin
      cycles_reg <= cycles_reg + 32'd1;
    end
  end

  assign kernel_cycles = cycles_reg;
`else
  assign kernel_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_block_dispatcher.sv
// Directed bench for block_dispatcher (4 cores, 8-bit IDs): launch table plus
// hand-written reset, simultaneous-retire and stats sequences.
module tb_block_dispatcher;
  localparam int NC = 4;
  localparam int BW = 8;
`ifdef BLOCK_DISPATCHER_STATS_EN
  localparam int EXP_KC = 7;
`else
  localparam int EXP_KC = 0;
`endif

  logic           clk;
  logic           reset;
  logic           start;
  logic [BW:0]    num_blocks;
  logic [NC-1:0]  core_enable;
  logic [NC-1:0]  core_done;
  logic [NC-1:0]  core_start;
  logic [NC-1:0]  core_reset;
  logic [NC*BW-1:0] core_block_id;
  logic [BW:0]    blocks_done;
  logic           done;
  logic           error;
  logic [31:0]    kernel_cycles;

  block_dispatcher #(.NUM_CORES(NC), .BLOCK_ID_WIDTH(BW)) dut (
    .clk(clk), .reset(reset), .start(start), .num_blocks(num_blocks),
    .core_enable(core_enable), .core_done(core_done), .core_start(core_start),
    .core_reset(core_reset), .core_block_id(core_block_id), .blocks_done(blocks_done),
    .done(done), .error(error), .kernel_cycles(kernel_cycles)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Core model: raises core_done resp_delay cycles into core_start, drops it when core_start falls.
  logic          auto_resp;
  int            resp_delay;
  logic [NC-1:0] auto_done;
  logic [NC-1:0] manual_done;
  int            resp_cnt [NC];
  assign core_done = auto_resp ? auto_done : manual_done;

  initial begin
    auto_done = '0;
    for (int i = 0; i < NC; i++) resp_cnt[i] = 0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NC; i++) begin
        if (auto_resp && core_start[i]) begin
          resp_cnt[i]++;
          if (resp_cnt[i] >= resp_delay) auto_done[i] = 1'b1;
        end else begin
          resp_cnt[i]  = 0;
          auto_done[i] = 1'b0;
        end
      end
    end
  end

  // Observation log, filled one negedge at a time.
  int            g_count;
  int            g_core [300];
  int            g_id   [300];
  int            first_rst_cyc;
  int            first_start_cyc;
  int            multi_grant;
  int            t_start;
  int            done_cyc;
  logic [NC-1:0] prev_start;

  task automatic clear_log();
    g_count         = 0;
    first_rst_cyc   = -1;
    first_start_cyc = -1;
    multi_grant     = 0;
    prev_start      = core_start;
  endtask

  task automatic tick();
    @(negedge clk);
    if ($countones(core_reset) > 1) multi_grant++;
    for (int i = 0; i < NC; i++) begin
      if (core_reset[i]) begin
        if (g_count < 300) begin
          g_core[g_count] = i;
          g_id[g_count]   = int'(core_block_id[i*BW +: BW]);
        end
        g_count++;
        if (first_rst_cyc < 0) first_rst_cyc = cyc;
      end
      if (core_start[i] && first_start_cyc < 0) first_start_cyc = cyc;
    end
    prev_start = core_start;
  endtask

  task automatic launch(input int nb, input logic [NC-1:0] en);
    clear_log();
    tick();
    start       = 1'b1;
    num_blocks  = (BW+1)'(nb);
    core_enable = en;
    t_start     = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int max_cycles);
    int n;
    n = 1;
    done_cyc = done ? cyc : -1;
    while (done_cyc < 0 && n < max_cycles) begin
      tick();
      n++;
      if (done) done_cyc = cyc;
    end
  endtask

  typedef struct {
    int            nb;
    logic [NC-1:0] en;
    int            delay;
    int            done_off;   // 0: completion time not checked
    logic          exp_err;
    int            exp_bd;
    int            exp_grants;
    int            map_len;
    logic [7:0][1:0] exp_map;  // expected core for grant k in element k
  } vec_t;

  vec_t vecs [5];

  initial begin
    int n;
    int bad;
    int fall_cyc;
    reset       = 1'b1;
    start       = 1'b0;
    num_blocks  = '0;
    core_enable = '0;
    manual_done = '0;
    auto_resp   = 1'b1;
    resp_delay  = 5;

    vecs[0] = '{4,   4'b0011, 5, 17, 1'b0, 4,   4,   4, {8'h00, 2'd1, 2'd0, 2'd1, 2'd0}};
    vecs[1] = '{0,   4'b1111, 5, 1,  1'b0, 0,   0,   0, 16'h0000};
    vecs[2] = '{3,   4'b0000, 5, 1,  1'b1, 0,   0,   0, 16'h0000};
    vecs[3] = '{3,   4'b0001, 2, 14, 1'b0, 3,   3,   3, 16'h0000};
    vecs[4] = '{256, 4'b1111, 3, 0,  1'b0, 256, 256, 0, 16'h0000};

    repeat (3) @(negedge clk);
    check("reset_core_start", core_start, 0);
    check("reset_core_reset", core_reset, 0);
    check("reset_block_id", core_block_id, 0);
    check("reset_blocks_done", blocks_done, 0);
    check("reset_done", done, 0);
    check("reset_error", error, 0);
    check("reset_kernel_cycles", kernel_cycles, 0);
    reset = 1'b0;
    tick();
    check("idle_done", done, 0);

    for (int v = 0; v < 5; v++) begin
      resp_delay = vecs[v].delay;
      launch(vecs[v].nb, vecs[v].en);
      wait_done(3000);
      $display("kernel %0d nb=%0d en=%b grants=%0d blocks_done=%0d done_at=+%0d error=%0d",
               v, vecs[v].nb, vecs[v].en, g_count, blocks_done, done_cyc - t_start, error);
      check($sformatf("v%0d_done", v), done, 1);
      if (vecs[v].done_off != 0)
        check($sformatf("v%0d_done_cycle", v), done_cyc, t_start + vecs[v].done_off);
      check($sformatf("v%0d_error", v), error, vecs[v].exp_err);
      check($sformatf("v%0d_blocks_done", v), blocks_done, vecs[v].exp_bd);
      check($sformatf("v%0d_grants", v), g_count, vecs[v].exp_grants);
      check($sformatf("v%0d_multi_grant", v), multi_grant, 0);
      if (vecs[v].exp_grants > 0) begin
        check($sformatf("v%0d_first_reset", v), first_rst_cyc, t_start + 2);
        check($sformatf("v%0d_first_start", v), first_start_cyc, t_start + 3);
      end else begin
        check($sformatf("v%0d_no_reset", v), first_rst_cyc, -1);
        check($sformatf("v%0d_no_start", v), first_start_cyc, -1);
      end
      for (int k = 0; k < g_count && k < 300; k++) begin
        check($sformatf("v%0d_id%0d", v, k), g_id[k], k % 256);
        if (k < vecs[v].map_len)
          check($sformatf("v%0d_core%0d", v, k), g_core[k], vecs[v].exp_map[k]);
      end
    end

    // Reset in the middle of a kernel with two blocks running.
    resp_delay = 20;
    launch(4, 4'b0011);
    n = 0;
    while (core_start != 4'b0011 && n < 10) begin
      tick();
      n++;
    end
    check("abort_setup_running", core_start, 4'b0011);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_core_start", core_start, 0);
    check("abort_core_reset", core_reset, 0);
    check("abort_block_id", core_block_id, 0);
    check("abort_blocks_done", blocks_done, 0);
    check("abort_done", done, 0);
    check("abort_error", error, 0);
    check("abort_kernel_cycles", kernel_cycles, 0);
    bad = 0;
    repeat (3) begin
      tick();
      if (core_reset != 0 || core_start != 0) bad++;
    end
    check("abort_no_pulses", bad, 0);

    // Single block after abort: core 0, ID 0; core_done lands 3 cycles after core_start.
    resp_delay = 4;
    launch(1, 4'b0011);
    wait_done(30);
    $display("kernel post-abort nb=1 grants=%0d done_at=+%0d kernel_cycles=%0d",
             g_count, done_cyc - t_start, kernel_cycles);
    check("post_done_cycle", done_cyc, t_start + 8);
    check("post_grants", g_count, 1);
    check("post_core", g_core[0], 0);
    check("post_id", g_id[0], 0);
    check("post_blocks_done", blocks_done, 1);
    check("post_kernel_cycles", kernel_cycles, EXP_KC);
    repeat (3) tick();
    check("post_kernel_cycles_hold", kernel_cycles, EXP_KC);
    check("post_done_hold", done, 1);

    // Cores 1 and 3 retire together three times; a start mid-kernel must be ignored.
    auto_resp   = 1'b0;
    manual_done = '0;
    launch(6, 4'b1010);
    fall_cyc = -1;
    for (int r = 0; r < 3; r++) begin
      n = 0;
      while (!(core_start[1] && core_start[3]) && n < 20) begin
        tick();
        n++;
      end
      check($sformatf("pair_r%0d_running", r), {core_start[3], core_start[1]}, 2'b11);
      check($sformatf("pair_r%0d_bd_before", r), blocks_done, 2 * r);
      manual_done = 4'b1010;
      if (r == 1) begin
        start      = 1'b1;
        num_blocks = '0;
      end
      tick();
      manual_done = '0;
      start       = 1'b0;
      fall_cyc    = cyc;
      check($sformatf("pair_r%0d_bd_after", r), blocks_done, 2 * r + 2);
      check($sformatf("pair_r%0d_stopped", r), {core_start[3], core_start[1]}, 2'b00);
      $display("pair retire %0d blocks_done=%0d", r, blocks_done);
    end
    wait_done(10);
    check("pair_done_cycle", done_cyc, fall_cyc + 1);
    check("pair_blocks_done", blocks_done, 6);
    check("pair_error", error, 0);
    check("pair_grants", g_count, 6);
    check("pair_multi_grant", multi_grant, 0);
    for (int k = 0; k < 6 && k < g_count; k++) begin
      check($sformatf("pair_core%0d", k), g_core[k], (k % 2 == 0) ? 1 : 3);
      check($sformatf("pair_id%0d", k), g_id[k], k);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
